ai_i2s_wb_tx_fifo: RTL and testbench



---
 rtl/ai_i2s_wb_tx_fifo.sv | 144 ++++++++++++++
 tb/tb_ai_i2s_wb_tx_fifo.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ai_i2s_wb_tx_fifo.sv
// Wishbone classic slave buffering I2S transmit samples in a synchronous FIFO.
// Optional level/flag interrupt output enabled by defining AI_I2S_TX_IRQ_EN.
module ai_i2s_wb_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int DW    = 32,
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic [31:0]   wb_adr_i,
  input  logic [1:0]    wb_bte_i,
  input  logic [2:0]    wb_cti_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic          wb_we_i,
  input  logic          wb_sel_i,
  input  logic [31:0]   wb_dat_i,
  output logic [31:0]   wb_dat_o,
  output logic          wb_ack_o,
  output logic [DW-1:0] smp_data_o,
  output logic          smp_valid_o,
  input  logic          smp_ready_i
`ifdef AI_I2S_TX_IRQ_EN
  ,
  output logic          irq_o
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          en, ovf, udf;
  logic [7:0]    thresh;

  logic        req, wr, rd;
  logic        a_ctrl, a_stat, a_tx;
  logic        empty, full, flush, push, push_ok, pop;
  logic        ovf_set, udf_set, ovf_clr, udf_clr;
  logic [31:0] rdata;
  logic        unused_ok;

  assign unused_ok = ^{wb_bte_i, wb_cti_i, wb_adr_i[31:4], wb_adr_i[1:0]};

  // Transactions commit on the edge that raises the ack.
  assign req    = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr     = req & wb_we_i & wb_sel_i;
  assign rd     = req & ~wb_we_i;
  assign a_ctrl = (wb_adr_i[3:2] == 2'd0);
  assign a_stat = (wb_adr_i[3:2] == 2'd1);
  assign a_tx   = (wb_adr_i[3:2] == 2'd2);

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign flush   = wr & a_ctrl & wb_dat_i[1];
  assign push    = wr & a_tx;
  assign push_ok = push & ~full;

  assign smp_valid_o = en & ~empty;
  assign smp_data_o  = empty ? '0 : mem[rd_ptr];
  assign pop         = smp_valid_o & smp_ready_i & ~flush;

  assign ovf_set = push & full;
  assign udf_set = en & smp_ready_i & empty;
  assign ovf_clr = wr & a_stat & wb_dat_i[2];
  assign udf_clr = wr & a_stat & wb_dat_i[3];

`ifndef AI_I2S_TX_IRQ_EN
  assign thresh = 8'd0;
`endif

  always_comb begin
    rdata = '0;
    case (wb_adr_i[3:2])
      2'd0: begin
        rdata[0]    = en;
        rdata[15:8] = thresh;
      end
      2'd1: begin
        rdata[0]          = empty;
        rdata[1]          = full;
        rdata[2]          = ovf;
        rdata[3]          = udf;
        rdata[LW+15:16]   = level;
      end
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      en       <= 1'b0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= rd ? rdata : 32'd0;
      if (wr & a_ctrl) en <= wb_dat_i[0];
      // Set wins over a same-cycle W1C.
      ovf <= ovf_set | (ovf & ~ovf_clr);
      udf <= udf_set | (udf & ~udf_clr);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
        case ({push_ok, pop})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: level <= level;
        endcase
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push_ok) mem[wr_ptr] <= wb_dat_i[DW-1:0];
  end

`ifdef AI_I2S_TX_IRQ_EN
  logic [15:0] level_ext, thresh_ext;
  assign level_ext  = 16'(level);
  assign thresh_ext = 16'(thresh);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      thresh <= 8'd0;
      irq_o  <= 1'b0;
    end else begin
      if (wr & a_ctrl) thresh <= wb_dat_i[15:8];
      irq_o <= (en & (level_ext <= thresh_ext)) | ovf | udf;
    end
  end
`endif

endmodule

// File: tb/tb_ai_i2s_wb_tx_fifo.sv
// Directed self-checking bench for ai_i2s_wb_tx_fifo (DEPTH=16, DW=32).
// The interrupt scenario runs only when AI_I2S_TX_IRQ_EN is defined.
module tb_ai_i2s_wb_tx_fifo;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr = '0;
  logic [1:0]  bte = '0;
  logic [2:0]  cti = '0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, sel = 1'b0;
  logic [31:0] wdat = '0;
  logic [31:0] dat_o;
  logic        ack;
  logic [31:0] smp_data;
  logic        smp_valid;
  logic        smp_ready = 1'b0;
`ifdef AI_I2S_TX_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] A_CTRL = 32'h0, A_STAT = 32'h4, A_TX = 32'h8, A_RSV = 32'hC;

  ai_i2s_wb_tx_fifo #(.DEPTH(16), .DW(32)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_bte_i(bte), .wb_cti_i(cti),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_sel_i(sel), .wb_dat_i(wdat),
    .wb_dat_o(dat_o), .wb_ack_o(ack), .smp_data_o(smp_data), .smp_valid_o(smp_valid),
    .smp_ready_i(smp_ready)
`ifdef AI_I2S_TX_IRQ_EN
    , .irq_o(irq)
`endif
  );

  always #5 clk = ~clk;

  // One bus transaction; optionally raises smp_ready for the committing edge.
  task automatic wb_xfer(input logic [31:0] a, input logic w, input logic s,
                         input logic [31:0] d, input logic pop,
                         output logic [31:0] rdat, output int lat);
    logic got;
    @(negedge clk);
    adr = a; we = w; sel = s; wdat = d; cyc = 1'b1; stb = 1'b1;
    if (pop) smp_ready = 1'b1;
    got = 1'b0; lat = 0; rdat = 32'hDEAD_BEEF;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (pop) smp_ready = 1'b0;
      if (ack) begin
        got = 1'b1; lat = n; rdat = dat_o;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 1'b0;
    if (!got) begin
      checks++; failures++;
      $display("FAIL ack_timeout adr=%h got no ack required ack within 8 cycles", a);
    end
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r; int l;
    wb_xfer(a, 1'b1, 1'b1, d, 1'b0, r, l);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] r);
    int l;
    wb_xfer(a, 1'b0, 1'b1, 32'h0, 1'b0, r, l);
  endtask

  // Checks the head sample at the current negedge, then pops it.
  task automatic pop_check(input logic [31:0] exp, input string name);
    checks++;
    if (smp_valid !== 1'b1 || smp_data !== exp) begin
      failures++;
      $display("FAIL %s valid=%b data=%h required valid=1 data=%h", name, smp_valid, smp_data, exp);
    end
    smp_ready = 1'b1;
    @(negedge clk);
    smp_ready = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] r; int l;
    repeat (3) @(negedge clk);
    checks++;
    if (ack !== 1'b0 || dat_o !== 32'h0 || smp_valid !== 1'b0 || smp_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs ack=%b dat=%h valid=%b data=%h required all 0", ack, dat_o, smp_valid, smp_data);
    end
    rst = 1'b0;
    wb_xfer(A_STAT, 1'b0, 1'b1, 32'h0, 1'b0, r, l);
    checks++;
    if (r !== 32'h0000_0001) begin
      failures++;
      $display("FAIL reset_status got=%h required=%h", r, 32'h1);
    end
    checks++;
    if (l !== 1) begin
      failures++;
      $display("FAIL ack_latency got=%0d required=1", l);
    end
    @(negedge clk);
    checks++;
    if (ack !== 1'b0 || dat_o !== 32'h0) begin
      failures++;
      $display("FAIL ack_pulse ack=%b dat=%h required ack=0 dat=0", ack, dat_o);
    end
  endtask

  task automatic test_sel_reserved;
    logic [31:0] r; int l;
    wb_xfer(A_TX, 1'b1, 1'b0, 32'h1234_5678, 1'b0, r, l);
    wb_xfer(A_CTRL, 1'b1, 1'b0, 32'h0000_0001, 1'b0, r, l);
    wb_write(A_RSV, 32'hFFFF_FFFF);
    wb_read(A_RSV, r);
    checks++;
    if (r !== 32'h0) begin failures++; $display("FAIL reserved_read got=%h required=0", r); end
    wb_read(A_TX, r);
    checks++;
    if (r !== 32'h0) begin failures++; $display("FAIL txdata_read got=%h required=0", r); end
    wb_read(A_CTRL, r);
    checks++;
    if (r !== 32'h0) begin failures++; $display("FAIL sel0_ctrl got=%h required=0", r); end
    wb_read(A_STAT, r);
    checks++;
    if (r !== 32'h0000_0001) begin failures++; $display("FAIL sel0_status got=%h required=%h", r, 32'h1); end
  endtask

  task automatic test_fill_overflow;
    logic [31:0] r;
    for (int i = 1; i <= 16; i++) wb_write(A_TX, 32'hA5A5_0000 + i);
    wb_read(A_STAT, r);
    checks++;
    if (r !== 32'h0010_0002) begin failures++; $display("FAIL full_status got=%h required=%h", r, 32'h0010_0002); end
    wb_write(A_TX, 32'hA5A5_0011);
    wb_read(A_STAT, r);
    checks++;
    if (r !== 32'h0010_0006) begin failures++; $display("FAIL overflow_status got=%h required=%h", r, 32'h0010_0006); end
    wb_write(A_STAT, 32'h4);
    wb_read(A_STAT, r);
    checks++;
    if (r !== 32'h0010_0002) begin failures++; $display("FAIL ovf_w1c got=%h required=%h", r, 32'h0010_0002); end
  endtask

  task automatic test_stream_underflow;
    logic [31:0] r;
    smp_ready = 1'b1;
    wb_write(A_CTRL, 32'h1);
    for (int i = 1; i <= 16; i++) begin
      checks++;
      if (smp_valid !== 1'b1 || smp_data !== 32'hA5A5_0000 + i) begin
        failures++;
        $display("FAIL stream_%0d valid=%b data=%h required valid=1 data=%h", i, smp_valid, smp_data, 32'hA5A5_0000 + i);
      end
      @(negedge clk);
    end
    checks++;
    if (smp_valid !== 1'b0) begin failures++; $display("FAIL drained_valid got=%b required=0", smp_valid); end
    @(negedge clk);
    smp_ready = 1'b0;
    wb_read(A_STAT, r);
    checks++;
    if (r !== 32'h0000_0009) begin failures++; $display("FAIL underflow_status got=%h required=%h", r, 32'h9); end
    wb_write(A_STAT, 32'h8);
    wb_read(A_STAT, r);
    checks++;
    if (r !== 32'h0000_0001) begin failures++; $display("FAIL udf_w1c got=%h required=%h", r, 32'h1); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] r; int l;
    for (int i = 0; i < 4; i++) wb_write(A_TX, 32'hB000_0000 + i);
    wb_read(A_STAT, r);
    checks++;
    if (r !== 32'h0004_0000) begin failures++; $display("FAIL level4 got=%h required=%h", r, 32'h0004_0000); end
    wb_xfer(A_TX, 1'b1, 1'b1, 32'hB000_0004, 1'b1, r, l);
    wb_read(A_STAT, r);
    checks++;
    if (r !== 32'h0004_0000) begin failures++; $display("FAIL push_pop_level got=%h required=%h", r, 32'h0004_0000); end
    for (int i = 1; i <= 4; i++) pop_check(32'hB000_0000 + i, "push_pop_order");
    for (int i = 0; i < 16; i++) wb_write(A_TX, 32'hC000_0000 + i);
    wb_xfer(A_TX, 1'b1, 1'b1, 32'hC000_0010, 1'b1, r, l);
    wb_read(A_STAT, r);
    checks++;
    if (r !== 32'h000F_0004) begin failures++; $display("FAIL full_push_pop got=%h required=%h", r, 32'h000F_0004); end
    checks++;
    if (smp_data !== 32'hC000_0001) begin failures++; $display("FAIL head_after_pop got=%h required=%h", smp_data, 32'hC000_0001); end
  endtask

  task automatic test_flush;
    logic [31:0] r; int l;
    wb_write(A_STAT, 32'h4);
    wb_write(A_CTRL, 32'h3);
    for (int i = 0; i < 8; i++) wb_write(A_TX, 32'hD000_0000 + i);
    wb_read(A_STAT, r);
    checks++;
    if (r !== 32'h0008_0000) begin failures++; $display("FAIL level8 got=%h required=%h", r, 32'h0008_0000); end
    wb_xfer(A_CTRL, 1'b1, 1'b1, 32'h3, 1'b1, r, l);
    checks++;
    if (smp_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b required=0", smp_valid); end
    wb_read(A_CTRL, r);
    checks++;
    if (r !== 32'h0000_0001) begin failures++; $display("FAIL flush_ctrl got=%h required=%h", r, 32'h1); end
    wb_read(A_STAT, r);
    checks++;
    if (r !== 32'h0000_0001) begin failures++; $display("FAIL flush_status got=%h required=%h", r, 32'h1); end
    wb_write(A_TX, 32'hE000_0000);
    pop_check(32'hE000_0000, "after_flush_head");
  endtask

`ifdef AI_I2S_TX_IRQ_EN
  task automatic test_irq;
    logic [31:0] r;
    wb_write(A_CTRL, 32'h0000_0200);
    for (int i = 0; i < 4; i++) wb_write(A_TX, 32'hF000_0000 + i);
    wb_write(A_CTRL, 32'h0000_0201);
    wb_read(A_CTRL, r);
    checks++;
    if (r !== 32'h0000_0201) begin failures++; $display("FAIL thresh_read got=%h required=%h", r, 32'h201); end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_level4 got=%b required=0", irq); end
    pop_check(32'hF000_0000, "irq_pop0");
    pop_check(32'hF000_0001, "irq_pop1");
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_same_cycle got=%b required=0", irq); end
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL irq_rise got=%b required=1", irq); end
    wb_write(A_TX, 32'hF000_0004);
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_clear got=%b required=0", irq); end
  endtask
`endif

  initial begin
    test_reset;
    test_sel_reserved;
    test_fill_overflow;
    test_stream_underflow;
    test_back_to_back;
    test_flush;
`ifdef AI_I2S_TX_IRQ_EN
    test_irq;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish required completion");
    $fatal(1, "timeout");
  end
endmodule
